// File: rtl/vector_alu_pipe.sv
// vector_alu_pipe: 2-stage valid/ready SIMD ALU, LANES independent DATA_W-bit lanes.
// Define VALU_SATURATE_EN for unsigned saturation of add, sub and add-4.
module vector_alu_pipe #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                op_sel,
    input  logic [LANES*DATA_W-1:0]   operand1,
    input  logic [LANES*DATA_W-1:0]   operand2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   result,
    output logic [LANES-1:0]          neg_flag,
    output logic [LANES-1:0]          zero_flag
);
    localparam int W = LANES * DATA_W;

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic [W-1:0]     alu_res;
    logic [LANES-1:0] alu_neg;
    logic [LANES-1:0] alu_zero;
    logic             s2_load;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    function automatic logic [DATA_W-1:0] lane_op(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0]   amt;
        logic [2*DATA_W-1:0] rr;
        logic [2*DATA_W-1:0] rl;
        logic [DATA_W-1:0]   add;
        logic [DATA_W-1:0]   sub;
        logic [DATA_W-1:0]   inc;
`ifdef VALU_SATURATE_EN
        logic [DATA_W:0]     sum;
        logic [DATA_W:0]     dif;
        logic [DATA_W:0]     inc_w;
        sum   = {1'b0, a} + {1'b0, b};
        dif   = {1'b0, a} - {1'b0, b};
        inc_w = {1'b0, a} + (DATA_W+1)'(4);
        add   = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
        sub   = dif[DATA_W] ? '0 : dif[DATA_W-1:0];
        inc   = inc_w[DATA_W] ? '1 : inc_w[DATA_W-1:0];
`else
        add = a + b;
        sub = a - b;
        inc = a + DATA_W'(4);
`endif
        // Rotating the doubled word keeps amount 0 an exact identity.
        amt = DATA_W'(b % DATA_W);
        rr  = {a, a} >> amt;
        rl  = {a, a} << amt;
        case (op)
            3'b001:  return a ^ b;
            3'b010:  return add;
            3'b011:  return sub;
            3'b100:  return a * b;
            3'b101:  return rr[DATA_W-1:0];
            3'b110:  return rl[2*DATA_W-1 -: DATA_W];
            3'b111:  return inc;
            default: return '0;
        endcase
    endfunction

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign alu_res[i*DATA_W +: DATA_W] = lane_op(s1_op, s1_a[i*DATA_W +: DATA_W], s1_b[i*DATA_W +: DATA_W]);
        assign alu_zero[i] = alu_res[i*DATA_W +: DATA_W] == '0;
        assign alu_neg[i]  = (s1_a[i*DATA_W + DATA_W - 1] != alu_res[i*DATA_W + DATA_W - 1]) && !alu_zero[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            neg_flag  <= '0;
            zero_flag <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_ready && in_valid) begin
                s1_op <= op_sel;
                s1_a  <= operand1;
                s1_b  <= operand2;
            end
            if (s2_load) out_valid <= s1_valid;
            if (s2_load && s1_valid) begin
                result    <= alu_res;
                neg_flag  <= alu_neg;
                zero_flag <= alu_zero;
            end
        end
    end
endmodule

// File: tb/tb_vector_alu_pipe.sv
// tb_vector_alu_pipe: directed and randomized checks of vector_alu_pipe against a lane-level model.
module tb_vector_alu_pipe;
    localparam int DW = 8;
    localparam int LN = 4;
    localparam int W  = DW * LN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op_sel = '0;
    logic [W-1:0]  operand1 = '0;
    logic [W-1:0]  operand2 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic [LN-1:0] neg_flag;
    logic [LN-1:0] zero_flag;

    int errors = 0;
    int checks = 0;
    logic [W-1:0]  q_r[$];
    logic [LN-1:0] q_n[$];
    logic [LN-1:0] q_z[$];

    always #5 clk = ~clk;

    vector_alu_pipe #(.DATA_W(DW), .LANES(LN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .neg_flag(neg_flag), .zero_flag(zero_flag)
    );

    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [LN-1:0] n, output logic [LN-1:0] z);
        for (int l = 0; l < LN; l++) begin
            int x;
            int y;
            int v;
            int k;
            x = int'(a[l*DW +: DW]);
            y = int'(b[l*DW +: DW]);
            k = y % DW;
            v = 0;
            case (op)
                3'd1: v = x ^ y;
                3'd2: v = x + y;
                3'd3: v = x - y;
                3'd4: v = x * y;
                3'd5: for (int j = 0; j < DW; j++) v |= ((x >> ((j + k) % DW)) & 1) << j;
                3'd6: for (int j = 0; j < DW; j++) v |= ((x >> ((j - k + DW) % DW)) & 1) << j;
                3'd7: v = x + 4;
                default: v = 0;
            endcase
`ifdef VALU_SATURATE_EN
            if ((op == 3'd2 || op == 3'd7) && v > (1 << DW) - 1) v = (1 << DW) - 1;
            if (op == 3'd3 && v < 0) v = 0;
`endif
            v = v & ((1 << DW) - 1);
            r[l*DW +: DW] = DW'(v);
            z[l] = (v == 0);
            n[l] = (((x >> (DW - 1)) & 1) != ((v >> (DW - 1)) & 1)) && (v != 0);
        end
    endfunction

    // One negedge-aligned cycle: drive, then score delivery and record acceptance for the coming edge.
    task automatic cycle(input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
        logic [W-1:0]  er;
        logic [LN-1:0] en;
        logic [LN-1:0] ez;
        @(negedge clk);
        in_valid = v; op_sel = op; operand1 = a; operand2 = b; out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            checks++;
            if (q_r.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: result=%h with no pending op", result);
            end else begin
                er = q_r.pop_front(); en = q_n.pop_front(); ez = q_z.pop_front();
                if (result !== er || neg_flag !== en || zero_flag !== ez) begin
                    errors++;
                    $display("FAIL stream: got r=%h n=%b z=%b, want r=%h n=%b z=%b", result, neg_flag, zero_flag, er, en, ez);
                end
            end
        end
        if (in_valid && in_ready) begin
            model(op, a, b, er, en, ez);
            q_r.push_back(er); q_n.push_back(en); q_z.push_back(ez);
        end
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && q_r.size() != 0; i++) cycle(1'b0, 3'd0, '0, '0, 1'b1);
        checks++;
        if (q_r.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d, want 0", q_r.size());
        end
        q_r.delete(); q_n.delete(); q_z.delete();
        cycle(1'b0, 3'd0, '0, '0, 1'b1);
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || neg_flag !== '0 || zero_flag !== '0) begin
            errors++;
            $display("FAIL reset_state: ov=%b ir=%b r=%h n=%b z=%b, want 0 1 0 0 0", out_valid, in_ready, result, neg_flag, zero_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ops;
        logic [2:0]    t_op[9];
        logic [W-1:0]  t_a[9];
        logic [W-1:0]  t_b[9];
        logic [W-1:0]  t_r[9];
        logic [LN-1:0] t_n[9];
        logic [LN-1:0] t_z[9];
        t_op[0] = 3'b010; t_a[0] = 32'h00FF107F; t_b[0] = 32'h00012001;
        t_op[1] = 3'b011; t_a[1] = 32'h05050505; t_b[1] = 32'h05050505; t_r[1] = 32'h0; t_n[1] = 4'b0000; t_z[1] = 4'b1111;
        t_op[2] = 3'b101; t_a[2] = 32'h00018181; t_b[2] = 32'h03010809; t_r[2] = 32'h008081C0; t_n[2] = 4'b0100; t_z[2] = 4'b1000;
        t_op[3] = 3'b110; t_a[3] = 32'h81818181; t_b[3] = 32'h00000100; t_r[3] = 32'h81810381; t_n[3] = 4'b0010; t_z[3] = 4'b0000;
        t_op[4] = 3'b010; t_a[4] = 32'hF0F0F0F0; t_b[4] = 32'h20202020;
        t_op[5] = 3'b100; t_a[5] = 32'h00000310; t_b[5] = 32'h00000510; t_r[5] = 32'h00000F00; t_n[5] = 4'b0000; t_z[5] = 4'b1101;
        t_op[6] = 3'b111; t_a[6] = 32'h7C0100FE; t_b[6] = 32'h12345678;
        t_op[7] = 3'b000; t_a[7] = 32'hDEADBEEF; t_b[7] = 32'h12345678; t_r[7] = 32'h0; t_n[7] = 4'b0000; t_z[7] = 4'b1111;
        t_op[8] = 3'b001; t_a[8] = 32'h5A5A5A5A; t_b[8] = 32'hA5A5A55A; t_r[8] = 32'hFFFFFF00; t_n[8] = 4'b1110; t_z[8] = 4'b0001;
`ifdef VALU_SATURATE_EN
        t_r[0] = 32'h00FF3080; t_n[0] = 4'b0001; t_z[0] = 4'b1000;
        t_r[4] = 32'hFFFFFFFF; t_n[4] = 4'b0000; t_z[4] = 4'b0000;
        t_r[6] = 32'h800504FF; t_n[6] = 4'b1000; t_z[6] = 4'b0000;
`else
        t_r[0] = 32'h00003080; t_n[0] = 4'b0001; t_z[0] = 4'b1100;
        t_r[4] = 32'h10101010; t_n[4] = 4'b1111; t_z[4] = 4'b0000;
        t_r[6] = 32'h80050402; t_n[6] = 4'b1001; t_z[6] = 4'b0000;
`endif
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op_sel = t_op[i]; operand1 = t_a[i]; operand2 = t_b[i]; out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL op%0d_in_ready: got %b, want 1", i, in_ready); end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL op%0d_early: out_valid=%b, want 0", i, out_valid); end
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== t_r[i] || neg_flag !== t_n[i] || zero_flag !== t_z[i]) begin
                errors++;
                $display("FAIL op%0d_result: ov=%b r=%h n=%b z=%b, want 1 r=%h n=%b z=%b", i, out_valid, result, neg_flag, zero_flag, t_r[i], t_n[i], t_z[i]);
            end
        end
        cycle(1'b0, 3'd0, '0, '0, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [2:0]    ops[3];
        logic [W-1:0]  a[3];
        logic [W-1:0]  b[3];
        logic [W-1:0]  er[3];
        logic [LN-1:0] en[3];
        logic [LN-1:0] ez[3];
        logic [3:0]    want_ir;
        ops[0] = 3'b010; ops[1] = 3'b001; ops[2] = 3'b011;
        for (int i = 0; i < 3; i++) begin
            a[i] = $urandom; b[i] = $urandom;
            model(ops[i], a[i], b[i], er[i], en[i], ez[i]);
        end
        want_ir = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = 1'b1; op_sel = ops[c > 2 ? 2 : c]; operand1 = a[c > 2 ? 2 : c]; operand2 = b[c > 2 ? 2 : c]; out_ready = 1'b0;
            #1;
            checks++;
            if (in_ready !== want_ir[c]) begin errors++; $display("FAIL b2b_ready_c%0d: got %b, want %b", c, in_ready, want_ir[c]); end
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || result !== er[0] || neg_flag !== en[0] || zero_flag !== ez[0]) begin
                    errors++;
                    $display("FAIL b2b_frozen_c%0d: ov=%b r=%h, want 1 r=%h", c, out_valid, result, er[0]);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (k > 0) in_valid = 1'b0;
            #1;
            checks++;
            if (k < 3 && (out_valid !== 1'b1 || result !== er[k] || neg_flag !== en[k] || zero_flag !== ez[k])) begin
                errors++;
                $display("FAIL b2b_deliver%0d: ov=%b r=%h n=%b z=%b, want 1 r=%h n=%b z=%b", k, out_valid, result, neg_flag, zero_flag, er[k], en[k], ez[k]);
            end
            if (k == 3 && out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra: out_valid=%b, want 0", out_valid); end
        end
    endtask

    task automatic test_throughput;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, 3'($urandom), $urandom, $urandom, 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL tput_ready%0d: got %b, want 1", i, in_ready); end
        end
        checks++;
        if (q_r.size() != 2) begin errors++; $display("FAIL tput_inflight: got %0d, want 2", q_r.size()); end
        drain();
    endtask

    task automatic test_random;
        repeat (400) cycle($urandom_range(0, 9) < 7, 3'($urandom), $urandom, $urandom, $urandom_range(0, 9) < 7);
        drain();
    endtask

    task automatic test_reset_mid;
        logic [W-1:0]  er;
        logic [LN-1:0] en;
        logic [LN-1:0] ez;
        cycle(1'b1, 3'b010, 32'h11223344, 32'h01010101, 1'b0);
        cycle(1'b1, 3'b001, 32'hAAAA5555, 32'h0F0F0F0F, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rmid_full: ov=%b ir=%b, want 1 0", out_valid, in_ready); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || neg_flag !== '0 || zero_flag !== '0) begin
            errors++;
            $display("FAIL rmid_async: ov=%b ir=%b r=%h n=%b z=%b, want 0 1 0 0 0", out_valid, in_ready, result, neg_flag, zero_flag);
        end
        q_r.delete(); q_n.delete(); q_z.delete();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; op_sel = 3'b111; operand1 = 32'h01020304; operand2 = '0; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_accept: in_ready=%b, want 1", in_ready); end
        model(op_sel, operand1, operand2, er, en, ez);
        q_r.push_back(er); q_n.push_back(en); q_z.push_back(ez);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
        test_throughput();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vector_alu_pipe.md
VECTOR_ALU_PIPE -- requirements
Module: vector_alu_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, lane width in bits (legal 4..32).
REQ-002 SHALL have parameter LANES, default 4, number of independent lanes (legal 1..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operation presented.
REQ-006 SHALL have port in_ready  output  1  block accepts operation this cycle.
REQ-007 SHALL have port op_sel  input  3  operation code, common to all lanes.
REQ-008 SHALL have port operand1  input  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port operand2  input  LANES*DATA_W  same packing as operand1.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port result  output  LANES*DATA_W  per-lane result, same packing.
REQ-013 SHALL have port neg_flag  output  LANES  per-lane negative flag.
REQ-014 SHALL have port zero_flag  output  LANES  per-lane zero flag.

Function
REQ-015 SHALL accept an operation when in_valid && in_ready; SHALL deliver it when out_valid && out_ready.
REQ-016 SHALL be a 2-stage pipeline: S1 registers op_sel/operands, S2 registers result/flags; accepted op at edge N appears with out_valid=1 after edge N+1.
REQ-017 SHALL load S2 when S2 empty or out_ready=1; SHALL load S1 when S1 empty or S2 loads; in_ready = !S1_valid || S2_load (combinational, no dependence on in_valid).
REQ-018 SHALL sustain one operation per cycle with out_ready held 1; no bubbles, no drops, no duplication.
REQ-019 SHALL hold result, flags, out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL compute per lane, modulo 2^DATA_W: 001 xor, 010 a+b, 011 a-b, 100 low DATA_W bits of a*b, 101 rotate a right by b mod DATA_W, 110 rotate a left by b mod DATA_W, 111 a+4, 000 result 0.
REQ-021 SHALL treat rotate amount 0 as identity (no shift-by-DATA_W artefact).
REQ-022 SHALL set zero_flag[i]=1 iff lane i result is 0.
REQ-023 SHALL set neg_flag[i]=1 iff operand1 MSB differs from result MSB and zero_flag[i]=0.
REQ-024 SHALL keep lanes fully independent; no carry or shift crosses a lane boundary.
REQ-025 SHALL, on simultaneous accept and deliver with both stages full, advance both stages in the same edge.

Reset
REQ-026 SHALL on rst_n=0, immediately and asynchronously clear S1/S2 valid, result, neg_flag, zero_flag to 0; in_ready reads 1 after reset.
REQ-027 SHALL discard any in-flight operations on reset mid-operation; no result emitted for them after release.
REQ-028 SHALL accept a new operation on the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL support macro VALU_SATURATE_EN: when defined, ops 010, 011, 111 saturate unsigned per lane (clamp to 2^DATA_W-1 on overflow, 0 on underflow); when undefined, they wrap modulo 2^DATA_W; all other ops identical either way.

Verification (DATA_W=8, LANES=4)
REQ-030 SHALL cover: lane0 op 010, 0x7F+0x01, out_ready=1 -> after 2 edges result 0x80, neg=1, zero=0.
REQ-031 SHALL cover: op 011, 0x05-0x05 all lanes -> result 0x00, zero_flag=4'b1111, neg_flag=4'b0000.
REQ-032 SHALL cover: op 101, a=0x81, b=0x09 -> 0xC0; op 110, a=0x81, b=0x00 -> 0x81.
REQ-033 SHALL cover: 3 back-to-back ops with out_ready=0 -> in_ready falls after 2 accepts, output frozen; out_ready=1 -> all 3 delivered in order, none lost.
REQ-034 SHALL cover: op 010, 0xF0+0x20 -> 0x10 without VALU_SATURATE_EN, 0xFF with it.
REQ-035 SHALL cover: rst_n pulsed low with both stages full -> out_valid=0 at once, no stale result after release.
